// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch SS.hh in four BCD digits, driven by the 100 Hz timebase tick.
// Run/pause/lap/clear control; display frozen from the lap latch in LAP.
module stopwatch_bcd_counter #(
  parameter bit WRAP    = 1'b1,
  parameter int MAX_SEC = 59
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       running,
  output logic       overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] LAP   = 2'd3;

  localparam logic [3:0] MAX_T = 4'(MAX_SEC / 10);
  localparam logic [3:0] MAX_U = 4'(MAX_SEC % 10);

  logic [1:0] state, state_n;
  logic [3:0] c3, c2, c1, c0;
  logic [3:0] n3, n2, n1, n0;
  logic [3:0] l3, l2, l1, l0;
  logic       cnt_en, term, ss_ok, latch, ovf_n;
  logic       w0, w1, w2;

  always_comb begin
    cnt_en = tick && !clear && (state == RUN || state == LAP);
    w0     = (c0 == 4'd9);
    w1     = (c1 == 4'd9);
    w2     = (c2 == 4'd9);
    term   = cnt_en && w0 && w1 && c3 == MAX_T && c2 == MAX_U;
    n3 = c3;
    n2 = c2;
    n1 = c1;
    n0 = c0;
    if (term) begin
      if (WRAP) begin
        n3 = 4'd0;
        n2 = 4'd0;
        n1 = 4'd0;
        n0 = 4'd0;
      end
    end else if (cnt_en) begin
      n0 = w0 ? 4'd0 : c0 + 4'd1;
      if (w0)
        n1 = w1 ? 4'd0 : c1 + 4'd1;
      if (w0 && w1)
        n2 = w2 ? 4'd0 : c2 + 4'd1;
      if (w0 && w1 && w2)
        n3 = (c3 == 4'd9) ? 4'd0 : c3 + 4'd1;
    end
  end

  // Sticky overflow in saturate mode locks out start_stop.
  always_comb begin
    ss_ok   = start_stop && !(overflow && !WRAP);
    state_n = state;
    latch   = 1'b0;
    if (clear) begin
      state_n = IDLE;
    end else if (term && !WRAP) begin
      state_n = PAUSE;
    end else if (ss_ok) begin
      unique case (state)
        IDLE, PAUSE: state_n = RUN;
        RUN, LAP:    state_n = PAUSE;
      endcase
    end else if (lap) begin
      if (state == RUN) begin
        state_n = LAP;
        latch   = 1'b1;
      end else if (state == LAP) begin
        state_n = RUN;
      end
    end
    if (clear)
      ovf_n = 1'b0;
    else if (term)
      ovf_n = 1'b1;
    else
      ovf_n = WRAP ? 1'b0 : overflow;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      overflow <= 1'b0;
      c3 <= '0; c2 <= '0; c1 <= '0; c0 <= '0;
      l3 <= '0; l2 <= '0; l1 <= '0; l0 <= '0;
    end else begin
      state    <= state_n;
      overflow <= ovf_n;
      if (clear) begin
        c3 <= '0; c2 <= '0; c1 <= '0; c0 <= '0;
        l3 <= '0; l2 <= '0; l1 <= '0; l0 <= '0;
      end else begin
        c3 <= n3; c2 <= n2; c1 <= n1; c0 <= n0;
        if (latch) begin
          l3 <= c3; l2 <= c2; l1 <= c1; l0 <= c0;
        end
      end
    end
  end

  always_comb begin
    running = (state == RUN) || (state == LAP);
    if (state == LAP) begin
      d3 = l3; d2 = l2; d1 = l1; d0 = l0;
    end else begin
      d3 = c3; d2 = c2; d1 = c1; d0 = c0;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: vector table, corner sequences and random
// traffic against an integer-hundredths model, for wrap and saturate builds.
module tb_stopwatch_bcd_counter;

  localparam int MAXC    = 5999;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  logic clk, reset_n;
  logic tick, start_stop, clear, lap;
  logic [3:0] a3, a2, a1, a0, b3, b2, b1, b0;
  logic run_a, ovf_a, run_b, ovf_b;
  logic [15:0] da, db;

  int checks = 0;
  int errors = 0;

  int m_cnt[2];
  int m_lap[2];
  int m_st[2];
  bit m_ovf[2];

  assign da = {a3, a2, a1, a0};
  assign db = {b3, b2, b1, b0};

  stopwatch_bcd_counter #(.WRAP(1'b1), .MAX_SEC(59)) dut_a (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .d3(a3), .d2(a2), .d1(a1), .d0(a0),
    .running(run_a), .overflow(ovf_a)
  );

  stopwatch_bcd_counter #(.WRAP(1'b0), .MAX_SEC(59)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .start_stop(start_stop), .clear(clear), .lap(lap),
    .d3(b3), .d2(b2), .d1(b1), .d0(b0),
    .running(run_b), .overflow(ovf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        t, s, c, l;
    logic [15:0] d;
    logic        run, ovf;
  } vec_t;

  vec_t vt[14];

  function automatic logic [15:0] bcd(input int v);
    int s, h;
    s = v / 100;
    h = v % 100;
    return {4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_lap[k] = 0;
      m_st[k]  = M_IDLE;
      m_ovf[k] = 1'b0;
    end
  endtask

  // Model works on total hundredths; k=0 wraps, k=1 saturates.
  task automatic m_step(input logic t, s, c, l);
    for (int k = 0; k < 2; k++) begin
      bit w, term, ovf_old;
      int old;
      w       = (k == 0);
      term    = 1'b0;
      old     = m_cnt[k];
      ovf_old = m_ovf[k];
      if (c) begin
        m_cnt[k] = 0;
        m_lap[k] = 0;
        m_st[k]  = M_IDLE;
        m_ovf[k] = 1'b0;
      end else begin
        if (t && (m_st[k] == M_RUN || m_st[k] == M_LAP)) begin
          if (old == MAXC) term = 1'b1;
          else m_cnt[k] = old + 1;
        end
        if (term && w) m_cnt[k] = 0;
        m_ovf[k] = term ? 1'b1 : (w ? 1'b0 : ovf_old);
        if (term && !w)
          m_st[k] = M_PAUSE;
        else if (s && !(ovf_old && !w))
          m_st[k] = (m_st[k] == M_IDLE || m_st[k] == M_PAUSE) ? M_RUN : M_PAUSE;
        else if (l) begin
          if (m_st[k] == M_RUN) begin
            m_st[k]  = M_LAP;
            m_lap[k] = old;
          end else if (m_st[k] == M_LAP) begin
            m_st[k] = M_RUN;
          end
        end
      end
    end
  endtask

  task automatic cyc(input logic t, s, c, l);
    @(negedge clk);
    tick = t; start_stop = s; clear = c; lap = l;
    @(posedge clk);
    m_step(t, s, c, l);
    #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmp_model();
    int v0, v1;
    v0 = (m_st[0] == M_LAP) ? m_lap[0] : m_cnt[0];
    v1 = (m_st[1] == M_LAP) ? m_lap[1] : m_cnt[1];
    chk("rnd_disp_a", da, bcd(v0));
    chk("rnd_run_a", run_a, (m_st[0] == M_RUN || m_st[0] == M_LAP) ? 1 : 0);
    chk("rnd_ovf_a", ovf_a, m_ovf[0]);
    chk("rnd_disp_b", db, bcd(v1));
    chk("rnd_run_b", run_b, (m_st[1] == M_RUN || m_st[1] == M_LAP) ? 1 : 0);
    chk("rnd_ovf_b", ovf_b, m_ovf[1]);
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};

    reset_n = 1'b0;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    m_reset();
    #12;
    chk("rst_disp", da, 16'h0000);
    chk("rst_run", run_a, 0);
    chk("rst_ovf", ovf_a, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].t, vt[i].s, vt[i].c, vt[i].l);
      chk($sformatf("vec%0d_disp", i), da, vt[i].d);
      chk($sformatf("vec%0d_run", i), run_a, vt[i].run);
      chk($sformatf("vec%0d_ovf", i), ovf_a, vt[i].ovf);
    end

    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(123);
    chk("t1_disp_a", da, 16'h0123);
    chk("t1_disp_b", db, 16'h0123);
    chk("t1_run", run_a, 1);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(9);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_pause_disp", da, 16'h0010);
    chk("t4_pause_run", run_a, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_resume_disp", da, 16'h0010);
    chk("t4_resume_run", run_a, 1);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(50);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(25);
    chk("t3_frozen", da, 16'h0050);
    chk("t3_run", run_a, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_live", da, 16'h0075);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1234);
    chk("t5_pre", da, 16'h1234);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_disp", da, 16'h0000);
    chk("t5_run", run_a, 0);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5999);
    chk("t2_top_a", da, 16'h5999);
    chk("t2_top_b", db, 16'h5999);
    ticks(1);
    chk("t2_wrap_disp", da, 16'h0000);
    chk("t2_wrap_ovf", ovf_a, 1);
    chk("t2_wrap_run", run_a, 1);
    chk("t2_sat_disp", db, 16'h5999);
    chk("t2_sat_ovf", ovf_b, 1);
    chk("t2_sat_run", run_b, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_wrap_pulse", ovf_a, 0);
    chk("t2_sat_sticky", ovf_b, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_sat_ss_ign", run_b, 0);
    chk("t2_sat_hold", db, 16'h5999);
    chk("t2_wrap_ss", run_a, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_clr_disp", db, 16'h0000);
    chk("t2_clr_ovf", ovf_b, 0);

    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(777);
    chk("t6_pre", da, 16'h0777);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    chk("t6_disp_a", da, 16'h0000);
    chk("t6_disp_b", db, 16'h0000);
    chk("t6_run", run_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_idle_tick", da, 16'h0000);
    chk("t6_idle_run", run_a, 0);

    for (int i = 0; i < 20000; i++) begin
      cyc($urandom_range(0, 9) != 0,
          $urandom_range(0, 299) == 0,
          $urandom_range(0, 19999) == 0,
          $urandom_range(0, 199) == 0);
      cmp_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
